// File: rtl/pc_shutdown_responder.sv
// Computer-side end of the no-break power interface: boots, runs, flushes dirty blocks on request, acknowledges halt.
// Optional feature macro: PC_AUTO_SAVE_ON_BATTERY_EN (flush dirty blocks while running on battery).
module pc_shutdown_responder #(
   parameter int BOOT_CYCLES  = 4,
   parameter int DIRTY_PERIOD = 3,
   parameter int NBLOCKS      = 8
) (
   input  logic       clk_2,
   input  logic       reset,
   input  logic       energia_entrada,
   input  logic       shutdown_req,
   input  logic       indicador_bateria,
   output logic       pc_ligado,
   output logic       salvando,
   output logic       desligado_ok,
   output logic [2:0] estado,
   output logic [3:0] blocos_sujos,
   output logic [7:0] blocos_salvos,
   output logic [3:0] num_perdas
);

   localparam int BW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam int TW = (DIRTY_PERIOD > 1) ? $clog2(DIRTY_PERIOD) : 1;
   localparam logic [BW-1:0] BOOT_LAST = BW'(BOOT_CYCLES - 1);
   localparam logic [TW-1:0] TMR_LAST  = TW'(DIRTY_PERIOD - 1);
   localparam logic [3:0]    NB_MAX    = 4'(NBLOCKS);

   typedef enum logic [2:0] {
      DESLIGADO = 3'd0,
      INICIANDO = 3'd1,
      OPERANDO  = 3'd2,
      SALVANDO  = 3'd3,
      PARANDO   = 3'd4,
      PARADO    = 3'd5
   } state_t;

   state_t        state, state_n;
   logic [BW-1:0] boot_cnt, boot_n;
   logic [TW-1:0] dirty_tmr, tmr_n;
   logic [3:0]    sujos_n, perdas_n;
   logic [7:0]    salvos_n;
   logic          auto_flush, auto_n;

   always_ff @(posedge clk_2) begin
      if (reset) begin
         state         <= DESLIGADO;
         boot_cnt      <= '0;
         dirty_tmr     <= '0;
         blocos_sujos  <= '0;
         blocos_salvos <= '0;
         num_perdas    <= '0;
         auto_flush    <= 1'b0;
      end else begin
         state         <= state_n;
         boot_cnt      <= boot_n;
         dirty_tmr     <= tmr_n;
         blocos_sujos  <= sujos_n;
         blocos_salvos <= salvos_n;
         num_perdas    <= perdas_n;
         auto_flush    <= auto_n;
      end
   end

   always_comb begin
      state_n  = state;
      boot_n   = boot_cnt;
      tmr_n    = dirty_tmr;
      sujos_n  = blocos_sujos;
      salvos_n = blocos_salvos;
      perdas_n = num_perdas;
      auto_n   = 1'b0;
      if (!energia_entrada && (state == INICIANDO || state == OPERANDO ||
                               state == SALVANDO  || state == PARANDO)) begin
         state_n = DESLIGADO;
         sujos_n = '0;
         if (num_perdas != 4'hF) perdas_n = num_perdas + 4'd1;
      end else if (!energia_entrada && state == PARADO) begin
         state_n = DESLIGADO;
      end else begin
         case (state)
            DESLIGADO: begin
               if (energia_entrada && !shutdown_req) begin
                  state_n = INICIANDO;
                  boot_n  = '0;
               end
            end
            INICIANDO: begin
               if (shutdown_req) begin
                  state_n = PARANDO;
               end else if (boot_cnt == BOOT_LAST) begin
                  state_n = OPERANDO;
                  tmr_n   = '0;
               end else begin
                  boot_n = boot_cnt + BW'(1);
               end
            end
            OPERANDO: begin
               // a shutdown request takes this cycle's dirty-timer tick
               if (shutdown_req) begin
                  state_n = (blocos_sujos != '0) ? SALVANDO : PARANDO;
`ifdef PC_AUTO_SAVE_ON_BATTERY_EN
               end else if (indicador_bateria) begin
                  if (blocos_sujos != '0) begin
                     sujos_n  = blocos_sujos - 4'd1;
                     salvos_n = blocos_salvos + 8'd1;
                     auto_n   = 1'b1;
                  end
`endif
               end else if (dirty_tmr == TMR_LAST) begin
                  tmr_n = '0;
                  if (blocos_sujos < NB_MAX) sujos_n = blocos_sujos + 4'd1;
               end else begin
                  tmr_n = dirty_tmr + TW'(1);
               end
            end
            SALVANDO: begin
               if (blocos_sujos != '0) begin
                  sujos_n  = blocos_sujos - 4'd1;
                  salvos_n = blocos_salvos + 8'd1;
               end
               if (blocos_sujos <= 4'd1) state_n = PARANDO;
            end
            PARANDO: state_n = PARADO;
            PARADO: begin
               if (!shutdown_req) state_n = DESLIGADO;
            end
            default: state_n = DESLIGADO;
         endcase
      end
   end

`ifdef PC_AUTO_SAVE_ON_BATTERY_EN
   assign salvando = (state == SALVANDO) || auto_flush;
`else
   logic unused_bateria;
   assign unused_bateria = indicador_bateria ^ auto_flush;
   assign salvando       = (state == SALVANDO);
`endif

   assign pc_ligado    = (state == INICIANDO) || (state == OPERANDO) || (state == SALVANDO);
   assign desligado_ok = (state == PARADO);
   assign estado       = state;

endmodule

// File: tb/tb_pc_shutdown_responder.sv
// Scoreboard bench for pc_shutdown_responder: directed scenarios plus random traffic against a reference model.
module tb_pc_shutdown_responder;

   localparam int BOOT = 4;
   localparam int PER  = 3;
   localparam int NB   = 8;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b1;
   logic       energia_entrada = 1'b0;
   logic       shutdown_req = 1'b0;
   logic       indicador_bateria = 1'b0;
   logic       pc_ligado, salvando, desligado_ok;
   logic [2:0] estado;
   logic [3:0] blocos_sujos, num_perdas;
   logic [7:0] blocos_salvos;

   pc_shutdown_responder #(
      .BOOT_CYCLES (BOOT),
      .DIRTY_PERIOD(PER),
      .NBLOCKS     (NB)
   ) dut (
      .clk_2            (clk_2),
      .reset            (reset),
      .energia_entrada  (energia_entrada),
      .shutdown_req     (shutdown_req),
      .indicador_bateria(indicador_bateria),
      .pc_ligado        (pc_ligado),
      .salvando         (salvando),
      .desligado_ok     (desligado_ok),
      .estado           (estado),
      .blocos_sujos     (blocos_sujos),
      .blocos_salvos    (blocos_salvos),
      .num_perdas       (num_perdas)
   );

   always #5 clk_2 = ~clk_2;

   typedef struct packed {
      logic       lig;
      logic       salv;
      logic       ok;
      logic [2:0] est;
      logic [3:0] suj;
      logic [7:0] sav;
      logic [3:0] per;
   } obs_t;

   obs_t exp_q[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc    = 0;

   // reference model: phase number, boot cycles left, OPERANDO ticks, counters
   int m_st = 0, m_left = 0, m_ticks = 0, m_dirty = 0, m_saved = 0, m_loss = 0;
   bit m_flush = 0;

   task automatic model_step(input bit rst, input bit en, input bit sd, input bit bat);
      int   nx;
      obs_t e;
      m_flush = 0;
      if (rst) begin
         m_st = 0; m_left = 0; m_ticks = 0; m_dirty = 0; m_saved = 0; m_loss = 0;
      end else begin
         nx = m_st;
         if (!en && m_st >= 1 && m_st <= 4) begin
            nx = 0;
            m_dirty = 0;
            if (m_loss < 15) m_loss++;
         end else if (!en && m_st == 5) begin
            nx = 0;
         end else begin
            case (m_st)
               0: if (en && !sd) begin nx = 1; m_left = BOOT; end
               1: begin
                  if (sd) nx = 4;
                  else begin
                     m_left--;
                     if (m_left == 0) begin nx = 2; m_ticks = 0; end
                  end
               end
               2: begin
                  if (sd) nx = (m_dirty > 0) ? 3 : 4;
`ifdef PC_AUTO_SAVE_ON_BATTERY_EN
                  else if (bat) begin
                     if (m_dirty > 0) begin
                        m_dirty--; m_saved = (m_saved + 1) % 256; m_flush = 1;
                     end
                  end
`endif
                  else begin
                     m_ticks++;
                     if (m_ticks % PER == 0 && m_dirty < NB) m_dirty++;
                  end
               end
               3: begin
                  m_dirty--;
                  m_saved = (m_saved + 1) % 256;
                  if (m_dirty == 0) nx = 4;
               end
               4: nx = 5;
               5: if (!sd) nx = 0;
               default: nx = 0;
            endcase
         end
         m_st = nx;
      end
      e.lig  = (m_st >= 1 && m_st <= 3);
      e.salv = (m_st == 3) || m_flush;
      e.ok   = (m_st == 5);
      e.est  = 3'(m_st);
      e.suj  = 4'(m_dirty);
      e.sav  = 8'(m_saved);
      e.per  = 4'(m_loss);
      exp_q.push_back(e);
   endtask

   task automatic drive(input bit rst, input bit en, input bit sd, input bit bat);
      @(negedge clk_2);
      reset             = rst;
      energia_entrada   = en;
      shutdown_req      = sd;
      indicador_bateria = bat;
      model_step(rst, en, sd, bat);
   endtask

   task automatic run(input int n, input bit en, input bit sd, input bit bat);
      for (int i = 0; i < n; i++) drive(1'b0, en, sd, bat);
   endtask

   // monitor: one observation per clock, compared with the oldest expectation
   always @(posedge clk_2) begin
      obs_t e, g;
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = {pc_ligado, salvando, desligado_ok, estado, blocos_sujos, blocos_salvos, num_perdas};
         checks++;
         if (g !== e) begin
            errors++;
            $display("FAIL outputs cyc=%0d got lig=%b salv=%b ok=%b est=%0d suj=%0d sav=%0d per=%0d exp lig=%b salv=%b ok=%b est=%0d suj=%0d sav=%0d per=%0d",
                     cyc, g.lig, g.salv, g.ok, g.est, g.suj, g.sav, g.per,
                     e.lig, e.salv, e.ok, e.est, e.suj, e.sav, e.per);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit sd, bat, en;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      // boot, 9 OPERANDO cycles, full flush, release and reboot
      run(14, 1'b1, 1'b0, 1'b0);
      run(7, 1'b1, 1'b1, 1'b0);
      run(2, 1'b1, 1'b0, 1'b0);
      // two dirty blocks, power lost during the flush
      run(10, 1'b1, 1'b0, 1'b0);
      run(1, 1'b1, 1'b1, 1'b0);
      run(2, 1'b0, 1'b0, 1'b0);
      // halt from INICIANDO, then power loss while in PARADO
      run(3, 1'b1, 1'b0, 1'b0);
      run(3, 1'b1, 1'b1, 1'b0);
      run(2, 1'b0, 1'b1, 1'b0);
      // repeated power losses in OPERANDO saturate num_perdas
      for (int k = 0; k < 16; k++) begin
         run(7, 1'b1, 1'b0, 1'b0);
         run(1, 1'b0, 1'b0, 1'b0);
      end
      // dirty-block saturation, then battery indication with dirty blocks
      run(46, 1'b1, 1'b0, 1'b0);
      run(10, 1'b1, 1'b0, 1'b1);
      run(6, 1'b1, 1'b1, 1'b0);
      run(2, 1'b1, 1'b0, 1'b0);
      // reset in the middle of operation
      run(12, 1'b1, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      // random traffic with level-held control inputs
      sd = 0; bat = 0; en = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 6)  sd  = ~sd;
         if ($urandom_range(99) < 8)  bat = ~bat;
         en = ($urandom_range(99) < 96);
         drive($urandom_range(999) < 4, en, sd, bat);
      end
      @(posedge clk_2);
      #3;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expectations, exp 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
